// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-DLX pipeline constants, NOP word and fetch state encoding
// Purpose : definitions shared by the fetch and decode stages.
// Contents: PC_W, INSTR_W, HALT_OPCODE, NOP, fetch_state_t (RUN/HALTED).
package mips_pkg;

   localparam int          PC_W        = 10;
   localparam int          INSTR_W     = 32;
   localparam logic [5:0]  HALT_OPCODE = 6'b111111;
   localparam logic [INSTR_W-1:0] NOP  = '0;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux with step gating and HALT qualification
// Purpose : pick the next PC for the RUN state and flag PC movement / HALT entry.
// Ports   : pc, pc_plus_1       - current PC and its increment
//           branch_taken/target - highest-priority redirect
//           jump_sel/target     - second-priority redirect
//           pc_write            - 0 holds the PC (hazard stall)
//           step_mode, step     - debug gating; advance only on step when step_mode=1
//           opcode              - instr[31:26] of the word currently fetched
//           pc_next             - selected next PC
//           count_en            - PC redirected, advanced, or HALT entered
//           halt_hit            - qualified HALT fetched this cycle
module pc_next_sel
   import mips_pkg::*;
#(
   parameter int         PC_W        = mips_pkg::PC_W,
   parameter logic [5:0] HALT_OPCODE = mips_pkg::HALT_OPCODE
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] pc_plus_1,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump_sel,
   input  logic [PC_W-1:0] jump_target,
   input  logic            pc_write,
   input  logic            step_mode,
   input  logic            step,
   input  logic [5:0]      opcode,
   output logic [PC_W-1:0] pc_next,
   output logic            count_en,
   output logic            halt_hit
);

   logic adv;

   assign adv = !step_mode || step;

   always_comb begin
      pc_next  = pc;
      count_en = 1'b0;
      halt_hit = 1'b0;
      if (branch_taken) begin
         pc_next  = branch_target;
         count_en = 1'b1;
      end else if (jump_sel) begin
         pc_next  = jump_target;
         count_en = 1'b1;
      end else if (pc_write && adv) begin
         // A HALT only counts when it is on the committed path and not stalled.
         if (opcode == HALT_OPCODE) begin
            halt_hit = 1'b1;
            count_en = 1'b1;
         end else begin
            pc_next  = pc_plus_1;
            count_en = 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS-DLX instruction fetch stage with HALT freeze and run-cycle counter
// Purpose : owns the PC, applies redirects/stalls/step gating, freezes on HALT.
// Ports   : enable        - pipeline clock (rising edge)
//           reset         - synchronous active-low reset
//           PC_write      - 0 holds the PC
//           branch_taken/branch_target, jump_sel/jump_target - redirects
//           step_mode, step - debug single-step gating
//           imem_addr/imem_data - asynchronous instruction memory port
//           instruc_out, PC_plus_1_out - to the IF/ID latch
//           halted        - fetch frozen after HALT
//           cycle_count   - cycles in which the PC moved or HALT was entered
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter int         PC_W        = mips_pkg::PC_W,
   parameter int         INSTR_W     = mips_pkg::INSTR_W,
   parameter logic [5:0] HALT_OPCODE = mips_pkg::HALT_OPCODE,
   parameter int         CNT_W       = 32
) (
   input  logic               enable,
   input  logic               reset,
   input  logic               PC_write,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               jump_sel,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               step_mode,
   input  logic               step,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instruc_out,
   output logic [PC_W-1:0]    PC_plus_1_out,
   output logic               halted,
   output logic [CNT_W-1:0]   cycle_count
);

   fetch_state_t    state, state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus_1;
   logic [PC_W-1:0] pc_next;
   logic            count_en;
   logic            halt_hit;

   assign pc_plus_1     = pc + PC_W'(1);
   assign imem_addr     = pc;
   assign PC_plus_1_out = pc_plus_1;
   assign halted        = (state == ST_HALTED);
   // The HALT word itself still leaves on its fetch cycle; NOPs follow.
   assign instruc_out   = (state == ST_RUN) ? imem_data : INSTR_W'(NOP);

   pc_next_sel #(
      .PC_W        (PC_W),
      .HALT_OPCODE (HALT_OPCODE)
   ) u_pc_next_sel (
      .pc            (pc),
      .pc_plus_1     (pc_plus_1),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump_sel      (jump_sel),
      .jump_target   (jump_target),
      .pc_write      (PC_write),
      .step_mode     (step_mode),
      .step          (step),
      .opcode        (imem_data[INSTR_W-1 -: 6]),
      .pc_next       (pc_next),
      .count_en      (count_en),
      .halt_hit      (halt_hit)
   );

   always_comb begin
      state_next = state;
      if (state == ST_RUN && halt_hit) begin
         state_next = ST_HALTED;
      end
   end

   always_ff @(posedge enable) begin
      if (!reset) begin
         state       <= ST_RUN;
         pc          <= '0;
         cycle_count <= '0;
      end else begin
         state <= state_next;
         if (state == ST_RUN) begin
            pc <= pc_next;
            if (count_en) begin
               cycle_count <= cycle_count + CNT_W'(1);
            end
         end
      end
   end

endmodule
